// File: rtl/idp_control_unit.sv
// Multicycle control unit for the integer datapath: decodes the external IR and sequences
// FETCH/DECODE/EXEC/MEM/WB. Optional macro IDP_CU_ILLEGAL_TRAP_EN makes illegal encodings trap.
module idp_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        z,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic [1:0]  pc_sel,
    output logic        im_cs,
    output logic        im_rd,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic        d_en,
    output logic [1:0]  d_sel,
    output logic        t_sel,
    output logic        imm_zext,
    output logic        hilo_ld,
    output logic [2:0]  y_sel,
    output logic [4:0]  fs,
    output logic        halt,
    output logic        illegal_op
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_MEM,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_NONE,
        C_RALU,
        C_IALU,
        C_MULDIV,
        C_MFHL,
        C_LW,
        C_SW,
        C_BR,
        C_J,
        C_BREAK,
        C_ILL
    } cls_t;

    localparam logic [4:0] FS_PASS_S = 5'h00;
    localparam logic [4:0] FS_ADD    = 5'h02;
    localparam logic [4:0] FS_ADDU   = 5'h03;
    localparam logic [4:0] FS_SUB    = 5'h04;
    localparam logic [4:0] FS_SUBU   = 5'h05;
    localparam logic [4:0] FS_SLT    = 5'h06;
    localparam logic [4:0] FS_SLTU   = 5'h07;
    localparam logic [4:0] FS_AND    = 5'h08;
    localparam logic [4:0] FS_OR     = 5'h09;
    localparam logic [4:0] FS_XOR    = 5'h0A;
    localparam logic [4:0] FS_NOR    = 5'h0B;
    localparam logic [4:0] FS_MUL    = 5'h1E;
    localparam logic [4:0] FS_DIV    = 5'h1F;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_BREAK = 6'h0D;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    cls_t       dec_cls;
    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_ir_bits;

    assign op = ir[31:26];
    assign fn = ir[5:0];
    // Register/immediate fields are consumed by the datapath, not by control.
    assign unused_ir_bits = ^ir[25:6];

    function automatic cls_t classify(input logic [5:0] opc, input logic [5:0] fnc);
        cls_t c;
        c = C_ILL;
        case (opc)
            OP_RTYPE: begin
                case (fnc)
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:      c = C_RALU;
                    FN_MULT, FN_DIV:   c = C_MULDIV;
                    FN_MFHI, FN_MFLO:  c = C_MFHL;
                    FN_BREAK:          c = C_BREAK;
                    default:           c = C_ILL;
                endcase
            end
            OP_J:                                    c = C_J;
            OP_BEQ, OP_BNE:                          c = C_BR;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: c = C_IALU;
            OP_LW:                                   c = C_LW;
            OP_SW:                                   c = C_SW;
            default:                                 c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [4:0] r_alu_fs(input logic [5:0] fnc);
        logic [4:0] f;
        f = FS_PASS_S;
        case (fnc)
            6'h20:   f = FS_ADD;
            6'h21:   f = FS_ADDU;
            6'h22:   f = FS_SUB;
            6'h23:   f = FS_SUBU;
            6'h24:   f = FS_AND;
            6'h25:   f = FS_OR;
            6'h26:   f = FS_XOR;
            6'h27:   f = FS_NOR;
            6'h2A:   f = FS_SLT;
            6'h2B:   f = FS_SLTU;
            default: f = FS_PASS_S;
        endcase
        return f;
    endfunction

    function automatic logic [4:0] i_alu_fs(input logic [5:0] opc);
        logic [4:0] f;
        f = FS_PASS_S;
        case (opc)
            OP_ADDI: f = FS_ADD;
            OP_SLTI: f = FS_SLT;
            OP_ANDI: f = FS_AND;
            OP_ORI:  f = FS_OR;
            OP_XORI: f = FS_XOR;
            default: f = FS_PASS_S;
        endcase
        return f;
    endfunction

    assign dec_cls = classify(op, fn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            cls_q   <= C_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        ir_ld      = 1'b0;
        pc_ld      = 1'b0;
        pc_sel     = 2'b00;
        im_cs      = 1'b0;
        im_rd      = 1'b0;
        dm_cs      = 1'b0;
        dm_rd      = 1'b0;
        dm_wr      = 1'b0;
        d_en       = 1'b0;
        d_sel      = 2'b00;
        t_sel      = 1'b0;
        imm_zext   = 1'b0;
        hilo_ld    = 1'b0;
        y_sel      = 3'd0;
        fs         = FS_PASS_S;
        halt       = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                im_cs   = 1'b1;
                im_rd   = 1'b1;
                ir_ld   = 1'b1;
                pc_ld   = 1'b1;
                pc_sel  = 2'b00;
                state_d = S_DECODE;
            end

            // RS/RT load at the end of this cycle; RT takes the immediate for I-type and memory ops.
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == C_IALU || dec_cls == C_LW || dec_cls == C_SW) begin
                    t_sel    = 1'b1;
                    imm_zext = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
                end
                case (dec_cls)
                    C_J: begin
                        pc_ld   = 1'b1;
                        pc_sel  = 2'b10;
                        state_d = S_FETCH;
                    end
                    C_MFHL:  state_d = S_WB;
                    C_BREAK: state_d = S_HALT;
`ifdef IDP_CU_ILLEGAL_TRAP_EN
                    C_ILL:   state_d = S_TRAP;
`else
                    C_ILL:   state_d = S_FETCH;
`endif
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (cls_q)
                    C_RALU: begin
                        fs      = r_alu_fs(fn);
                        state_d = S_WB;
                    end
                    C_IALU: begin
                        t_sel   = 1'b1;
                        fs      = i_alu_fs(op);
                        state_d = S_WB;
                    end
                    C_MULDIV: begin
                        fs      = (fn == FN_DIV) ? FS_DIV : FS_MUL;
                        hilo_ld = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_LW: begin
                        fs      = FS_ADD;
                        t_sel   = 1'b1;
                        state_d = S_MEM;
                    end
                    C_SW: begin
                        // t_sel=0 reloads RT with register data for the store.
                        fs      = FS_ADD;
                        state_d = S_MEM;
                    end
                    C_BR: begin
                        fs = FS_SUB;
                        if ((op == OP_BEQ) ? z : !z) begin
                            pc_ld  = 1'b1;
                            pc_sel = 2'b01;
                        end
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                dm_cs = 1'b1;
                if (cls_q == C_LW) begin
                    dm_rd   = 1'b1;
                    state_d = S_WB;
                end else begin
                    dm_wr   = (cls_q == C_SW);
                    state_d = S_FETCH;
                end
            end

            S_WB: begin
                d_en    = 1'b1;
                state_d = S_FETCH;
                case (cls_q)
                    C_RALU: begin
                        y_sel = 3'd2;
                        d_sel = 2'b00;
                    end
                    C_IALU: begin
                        y_sel = 3'd2;
                        d_sel = 2'b01;
                    end
                    C_MFHL: begin
                        y_sel = (fn == FN_MFLO) ? 3'd1 : 3'd0;
                        d_sel = 2'b00;
                    end
                    C_LW: begin
                        y_sel = 3'd3;
                        d_sel = 2'b01;
                    end
                    default: d_en = 1'b0;
                endcase
            end

            S_HALT: halt = 1'b1;

            S_TRAP: begin
`ifdef IDP_CU_ILLEGAL_TRAP_EN
                illegal_op = 1'b1;
                halt       = 1'b1;
`else
                state_d    = S_FETCH;
`endif
            end

            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_idp_control_unit.sv
// Directed bench for idp_control_unit: a per-instruction expected-cycle model feeds a queue that
// one negedge compare process checks against the DUT outputs.
module tb_idp_control_unit;

    typedef struct packed {
        logic       ir_ld;
        logic       pc_ld;
        logic [1:0] pc_sel;
        logic       im_cs;
        logic       im_rd;
        logic       dm_cs;
        logic       dm_rd;
        logic       dm_wr;
        logic       d_en;
        logic [1:0] d_sel;
        logic       t_sel;
        logic       imm_zext;
        logic       hilo_ld;
        logic [2:0] y_sel;
        logic [4:0] fs;
        logic       halt;
        logic       illegal_op;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        z = 1'b0;
    logic        ir_ld, pc_ld, im_cs, im_rd, dm_cs, dm_rd, dm_wr, d_en;
    logic        t_sel, imm_zext, hilo_ld, halt, illegal_op;
    logic [1:0]  pc_sel, d_sel;
    logic [2:0]  y_sel;
    logic [4:0]  fs;
    out_t        dut_o;

    int    errors = 0;
    int    checks = 0;
    out_t  exp_q[$];
    string name_q[$];

    idp_control_unit dut (
        .clk(clk), .reset(reset), .ir(ir), .z(z),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_sel(pc_sel),
        .im_cs(im_cs), .im_rd(im_rd),
        .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .d_en(d_en), .d_sel(d_sel), .t_sel(t_sel), .imm_zext(imm_zext),
        .hilo_ld(hilo_ld), .y_sel(y_sel), .fs(fs),
        .halt(halt), .illegal_op(illegal_op)
    );

    assign dut_o = {ir_ld, pc_ld, pc_sel, im_cs, im_rd, dm_cs, dm_rd, dm_wr, d_en,
                    d_sel, t_sel, imm_zext, hilo_ld, y_sel, fs, halt, illegal_op};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            out_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (dut_o !== e) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", nm, dut_o, e);
            end
        end
    end

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, want);
        end
    endtask

    task automatic push(input string nm, input out_t v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    function automatic logic [4:0] r_code(input logic [5:0] f);
        case (f)
            6'h20: return 5'h02;
            6'h21: return 5'h03;
            6'h22: return 5'h04;
            6'h23: return 5'h05;
            6'h24: return 5'h08;
            6'h25: return 5'h09;
            6'h26: return 5'h0A;
            6'h27: return 5'h0B;
            6'h2A: return 5'h06;
            6'h2B: return 5'h07;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [4:0] i_code(input logic [5:0] o);
        case (o)
            6'h08: return 5'h02;
            6'h0A: return 5'h06;
            6'h0C: return 5'h08;
            6'h0D: return 5'h09;
            6'h0E: return 5'h0A;
            default: return 5'h00;
        endcase
    endfunction

    // Expected output vector for every cycle of one instruction, starting at its FETCH.
    task automatic model(input string nm, input logic [31:0] i, input logic zz);
        logic [5:0] op, fn;
        out_t v;
        op = i[31:26];
        fn = i[5:0];
        v = '0; v.ir_ld = 1; v.pc_ld = 1; v.im_cs = 1; v.im_rd = 1;
        push({nm, ".F"}, v);
        if (op == 6'h00 && r_code(fn) != 5'h00) begin
            v = '0; push({nm, ".D"}, v);
            v.fs = r_code(fn); push({nm, ".E"}, v);
            v = '0; v.y_sel = 2; v.d_en = 1; push({nm, ".WB"}, v);
        end else if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
            v = '0; push({nm, ".D"}, v);
            v.fs = (fn == 6'h18) ? 5'h1E : 5'h1F; v.hilo_ld = 1; push({nm, ".E"}, v);
        end else if (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
            v = '0; push({nm, ".D"}, v);
            v.y_sel = (fn == 6'h12) ? 3'd1 : 3'd0; v.d_en = 1; push({nm, ".WB"}, v);
        end else if (op == 6'h00 && fn == 6'h0D) begin
            v = '0; push({nm, ".D"}, v);
            v.halt = 1;
            for (int k = 0; k < 4; k++) push({nm, ".HALT"}, v);
        end else if (op == 6'h02) begin
            v = '0; v.pc_ld = 1; v.pc_sel = 2'b10; push({nm, ".D"}, v);
        end else if (op == 6'h04 || op == 6'h05) begin
            v = '0; push({nm, ".D"}, v);
            v.fs = 5'h04;
            if ((op == 6'h04 && zz) || (op == 6'h05 && !zz)) begin
                v.pc_ld = 1; v.pc_sel = 2'b01;
            end
            push({nm, ".E"}, v);
        end else if (i_code(op) != 5'h00) begin
            v = '0; v.t_sel = 1; v.imm_zext = (op == 6'h0C || op == 6'h0D || op == 6'h0E);
            push({nm, ".D"}, v);
            v = '0; v.t_sel = 1; v.fs = i_code(op); push({nm, ".E"}, v);
            v = '0; v.y_sel = 2; v.d_sel = 1; v.d_en = 1; push({nm, ".WB"}, v);
        end else if (op == 6'h23) begin
            v = '0; v.t_sel = 1; push({nm, ".D"}, v);
            v.fs = 5'h02; push({nm, ".E"}, v);
            v = '0; v.dm_cs = 1; v.dm_rd = 1; push({nm, ".MEM"}, v);
            v = '0; v.y_sel = 3; v.d_sel = 1; v.d_en = 1; push({nm, ".WB"}, v);
        end else if (op == 6'h2B) begin
            v = '0; v.t_sel = 1; push({nm, ".D"}, v);
            v = '0; v.fs = 5'h02; push({nm, ".E"}, v);
            v = '0; v.dm_cs = 1; v.dm_wr = 1; push({nm, ".MEM"}, v);
        end else begin
            v = '0; push({nm, ".D"}, v);
`ifdef IDP_CU_ILLEGAL_TRAP_EN
            v.halt = 1; v.illegal_op = 1;
            for (int k = 0; k < 4; k++) push({nm, ".TRAP"}, v);
`endif
        end
    endtask

    // Returns one tick after a rising edge, once every queued expectation has been compared.
    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d exp=0 pending", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic run(input string nm, input logic [31:0] i, input logic zz, input int cpi);
        wait_drain();
        ir = i;
        z  = zz;
        model(nm, i, zz);
        check_val({nm, ".model_len"}, exp_q.size(), cpi);
    endtask

    task automatic do_reset(input string nm);
        wait_drain();
        reset = 1'b1;
        #1;
        check_val({nm, ".async_zero"}, {7'b0, dut_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push({nm, ".RESET"}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t v;
        repeat (3) @(posedge clk);
        #1;
        check_val("por.zero", {7'b0, dut_o}, 32'h0);
        reset = 1'b0;
        push("por.RESET", '0);

        run("add",   32'h00221820, 1'b0, 4);
        run("sub",   32'h00221822, 1'b0, 4);
        run("slt",   32'h0022182A, 1'b0, 4);
        run("nor",   32'h00221827, 1'b0, 4);
        run("sltu",  32'h0022182B, 1'b0, 4);
        run("addi",  32'h20250004, 1'b0, 4);
        run("slti",  32'h28250004, 1'b0, 4);
        run("andi",  32'h30250004, 1'b0, 4);
        run("ori",   32'h34250004, 1'b0, 4);
        run("xori",  32'h38250004, 1'b0, 4);
        run("lw",    32'h8C250004, 1'b0, 5);
        run("sw",    32'hAC250004, 1'b0, 4);
        run("beq_t", 32'h10220003, 1'b1, 3);
        run("beq_n", 32'h10220003, 1'b0, 3);
        run("bne_t", 32'h14220003, 1'b0, 3);
        run("bne_n", 32'h14220003, 1'b1, 3);
        run("mult",  32'h00220018, 1'b0, 3);
        run("mflo",  32'h00001812, 1'b0, 3);
        run("div",   32'h0022001A, 1'b0, 3);
        run("mfhi",  32'h00001810, 1'b0, 3);
        run("j",     32'h08000010, 1'b0, 2);
        run("add2",  32'h00221820, 1'b0, 4);

        // Abort an add in EXEC: outputs must drop with reset, before any clock edge.
        wait_drain();
        ir = 32'h00221820;
        z  = 1'b0;
        v = '0; v.ir_ld = 1; v.pc_ld = 1; v.im_cs = 1; v.im_rd = 1;
        push("abort.F", v);
        push("abort.D", '0);
        wait_drain();
        check_val("abort.exec_fs", {27'b0, fs}, 32'h02);
        #2;
        reset = 1'b1;
        #1;
        check_val("abort.async_zero", {7'b0, dut_o}, 32'h0);
        @(posedge clk); #1;
        check_val("abort.held_zero", {7'b0, dut_o}, 32'h0);
        reset = 1'b0;
        push("abort.RESET", '0);
        run("post_abort_add", 32'h00221820, 1'b0, 4);

        run("break", 32'h0000000D, 1'b0, 6);
        do_reset("rst_break");
        run("after_break", 32'h8C250004, 1'b0, 5);

`ifdef IDP_CU_ILLEGAL_TRAP_EN
        run("ill_op", 32'hFC000000, 1'b0, 6);
        do_reset("rst_ill_op");
        run("ill_fn", 32'h0000003F, 1'b0, 6);
        do_reset("rst_ill_fn");
`else
        run("ill_op", 32'hFC000000, 1'b0, 2);
        run("ill_fn", 32'h0000003F, 1'b0, 2);
`endif
        run("final_sw", 32'hAC250004, 1'b0, 4);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idp_control_unit.md
# idp_control_unit

Multicycle control unit that sequences the integer datapath (register file, RS/RT registers, ALU, HI/LO, ALU_OUT and D_in registers, Y-mux) together with the external PC, IR and data memory. It decodes the 32-bit instruction held in the external IR and drives every datapath select, write-enable and function code one state at a time. It also drives the memory strobes and the PC update controls. It sits beside the datapath in the CPU top level and is the only driver of its control inputs.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- ir  in  32  current instruction from external IR
- z  in  1  ALU zero flag (combinational, from datapath)
- ir_ld, pc_ld  out  1  load IR / load PC at end of cycle
- pc_sel  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target
- im_cs, im_rd  out  1  instruction memory strobes
- dm_cs, dm_rd, dm_wr  out  1  data memory strobes
- d_en  out  1  register-file write enable
- d_sel  out  2  destination: 00 rd, 01 rt
- t_sel  out  1  RT-register source: 0 register file, 1 immediate
- imm_zext  out  1  immediate extender: 1 zero-extend, 0 sign-extend
- hilo_ld  out  1  load HI/LO
- y_sel  out  3  Y-mux: 0 HI, 1 LO, 2 ALU_OUT, 3 D_in
- fs  out  5  ALU function
- halt  out  1  processor halted
- illegal_op  out  1  trap flag (macro-dependent, see Configuration)

## Operation
- FS codes: PASS_S 00, ADD 02, ADDU 03, SUB 04, SUBU 05, SLT 06, SLTU 07, AND 08, OR 09, XOR 0A, NOR 0B, MUL 1E, DIV 1F.
- States: RESET, FETCH, DECODE, EXEC, WB, MEM, HALT, TRAP; the operation class is latched in DECODE.
- RESET goes to FETCH on the first edge after reset deasserts.
- FETCH: im_cs=im_rd=ir_ld=pc_ld=1, pc_sel=00. Always goes to DECODE.
- DECODE: t_sel=1 and imm_zext=(opcode∈{0C,0D,0E}) for I-type ALU ops, lw and sw; t_sel=0 otherwise.
- DECODE next state:
  - j (op 02): pc_ld=1, pc_sel=10, then FETCH.
  - mfhi (R funct 10) and mflo (R funct 12): go to WB.
  - break (R funct 0D): go to HALT.
  - Unrecognised opcode or funct: go to TRAP.
  - All other instructions: go to EXEC.
- R-type ALU (funct 20–27, 2A, 2B): EXEC sets fs per funct (ADD…NOR, SLT, SLTU). WB: y_sel=2, d_sel=00, d_en=1.
- I-type ALU (addi 08, slti 0A, andi 0C, ori 0D, xori 0E): EXEC holds t_sel=1 and fs=ADD/SLT/AND/OR/XOR. WB: y_sel=2, d_sel=01, d_en=1.
- mult (funct 18) / div (funct 1A): EXEC sets fs=MUL/DIV and hilo_ld=1, then FETCH.
- mfhi / mflo: WB sets y_sel=0 / 1, d_sel=00, d_en=1.
- lw (23):
  - EXEC: fs=ADD, t_sel=1.
  - MEM: dm_cs=dm_rd=1 (D_in captures).
  - WB: y_sel=3, d_sel=01, d_en=1.
- sw (2B):
  - EXEC: fs=ADD, t_sel=0, so the RT register reloads rt data.
  - MEM: dm_cs=dm_wr=1; address comes from ALU_OUT, data from RT register. Then FETCH.
- beq (04) / bne (05): EXEC sets fs=SUB and t_sel=0. pc_ld=1 and pc_sel=01 when z=1 (beq) or z=0 (bne). Then FETCH.
- WB always goes to FETCH.
- HALT: halt=1; leaves only on reset.
- In every state, any output not named is 0.

## Timing
- All outputs are decoded combinationally from the state register and ir (Moore plus ir decode).
- Reset: every output is 0 and the state is RESET, immediately and asynchronously.
- Cycles per instruction:
  - R-type/I-type ALU: 4
  - lw: 5
  - sw: 4
  - mult/div: 3
  - mfhi/mflo: 3
  - beq/bne: 3
  - j: 2
- The branch decision uses z during EXEC, after RS/RT were loaded at the end of DECODE.
- Reset asserted mid-instruction aborts it: no d_en, dm_wr or pc_ld is issued after the reset edge.
- At most one of dm_rd and dm_wr is high in any cycle. d_en and hilo_ld are never high together.

## Configuration
- IDP_CU_ILLEGAL_TRAP_EN defined: TRAP asserts illegal_op=1 and halt=1 and holds until reset.
- IDP_CU_ILLEGAL_TRAP_EN undefined: illegal encodings go from DECODE to FETCH (NOP, 2 cycles), and illegal_op is tied to 0.

## Test plan
- Reset mid-EXEC of add: all outputs drop to 0 at once. After release: RESET→FETCH, with im_cs=ir_ld=pc_ld=1 in the second cycle.
- add $3,$1,$2 (ir=00221820): states F,D,E,WB. fs=02 in E. WB has y_sel=2, d_sel=0, d_en=1 for exactly one cycle.
- lw $5,4($1) (ir=8C250004):
  - D: t_sel=1, imm_zext=0.
  - MEM: dm_cs=dm_rd=1.
  - WB: y_sel=3, d_sel=1, d_en=1.
  - 5 cycles total.
- beq with z=1 → pc_ld=1, pc_sel=01 in EXEC. Same beq with z=0 → pc_ld=0. bne inverts both.
- mult (ir=00220018): hilo_ld=1, fs=1E in EXEC. Then mflo: WB y_sel=1, d_en=1.
- ir=FC000000 with macro: illegal_op=halt=1 and held. Without macro: returns to FETCH after DECODE, illegal_op=0.
